// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul result writer: dimension derivation,
// drain state encoding and element index/address arithmetic.
package matmul_pkg;

    localparam int DIM_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WRITE,
        DONE
    } state_e;

    function automatic int max_dim(input int data_w, input int bus_w);
        return bus_w / data_w;
    endfunction

    // Flat C/flags storage is column-major: (r,c) lives at c*dim + r.
    function automatic int elem_index(input int r, input int c, input int dim);
        return c * dim + r;
    endfunction

    // Scratchpad layout is row-major relative to the base address.
    function automatic int elem_offset(input int r, input int c, input int dim);
        return r * dim + c;
    endfunction

endpackage

// File: rtl/sat_add_module.sv
// Combinational signed saturating adder: clamps to the most positive/negative
// value when both operands share a sign the raw sum does not.
module sat_add_module
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH = 16
) (
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    output logic [BUS_WIDTH-1:0] sum_o,
    output logic                 overflow_o
);

    logic [BUS_WIDTH-1:0] raw;

    always_comb begin
        raw        = a_i + b_i;
        overflow_o = (a_i[BUS_WIDTH-1] == b_i[BUS_WIDTH-1]) &&
                     (raw[BUS_WIDTH-1] != a_i[BUS_WIDTH-1]);
        if (!overflow_o) begin
            sum_o = raw;
        end else if (a_i[BUS_WIDTH-1]) begin
            sum_o = {1'b1, {(BUS_WIDTH-1){1'b0}}};
        end else begin
            sum_o = {1'b0, {(BUS_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/matmul_result_writer.sv
// Drains the systolic multiplier's C matrix and overflow flags into the result
// scratchpad, optionally accumulating onto existing contents with saturation.
module matmul_result_writer
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUS_WIDTH  = 16,
    parameter  int ADDR_WIDTH = 5,
    localparam int MAX_DIM    = max_dim(DATA_WIDTH, BUS_WIDTH)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   finish_mul_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   c_matrix_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]             flags_i,
    input  logic [1:0]                             n_dim_i,
    input  logic [1:0]                             m_dim_i,
    input  logic                                   acc_mode_i,
    input  logic [ADDR_WIDTH-1:0]                  sp_base_i,
    output logic                                   wr_en_o,
    output logic [ADDR_WIDTH-1:0]                  wr_addr_o,
    output logic [BUS_WIDTH-1:0]                   wr_data_o,
    input  logic                                   wr_ready_i,
    output logic                                   rd_en_o,
    output logic [ADDR_WIDTH-1:0]                  rd_addr_o,
    input  logic [BUS_WIDTH-1:0]                   rd_data_i,
    input  logic                                   rd_valid_i,
    output logic [MAX_DIM*MAX_DIM-1:0]             flags_o,
    output logic                                   finish_write_o
);

    localparam int NEL = MAX_DIM * MAX_DIM;

    state_e                   state_q;
    logic [NEL*BUS_WIDTH-1:0] c_q;
    logic [DIM_W-1:0]         n_q;
    logic [DIM_W-1:0]         m_q;
    logic [DIM_W-1:0]         row_q;
    logic [DIM_W-1:0]         col_q;
    logic                     acc_q;
    logic [ADDR_WIDTH-1:0]    base_q;

    logic [DIM_W-1:0]         row_d;
    logic [DIM_W-1:0]         col_d;
    logic                     last_elem;
    logic [BUS_WIDTH-1:0]     c_cur;
    logic [BUS_WIDTH-1:0]     c_next;
    logic [ADDR_WIDTH-1:0]    addr_next;
    logic [BUS_WIDTH-1:0]     sum;
    logic                     ovf;
    logic [NEL-1:0]           flags_d;

    sat_add_module #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_sat_add (
        .a_i        (rd_data_i),
        .b_i        (c_cur),
        .sum_o      (sum),
        .overflow_o (ovf)
    );

    always_comb begin
        last_elem = (row_q == n_q) && (col_q == m_q);
        if (col_q == m_q) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
        end else begin
            col_d = col_q + DIM_W'(1);
            row_d = row_q;
        end
        c_cur     = c_q[elem_index(int'(row_q), int'(col_q), MAX_DIM)*BUS_WIDTH +: BUS_WIDTH];
        c_next    = c_q[elem_index(int'(row_d), int'(col_d), MAX_DIM)*BUS_WIDTH +: BUS_WIDTH];
        addr_next = ADDR_WIDTH'(int'(base_q) + elem_offset(int'(row_d), int'(col_d), MAX_DIM));
        flags_d   = flags_o | (NEL'(ovf) << elem_index(int'(row_q), int'(col_q), MAX_DIM));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            c_q            <= '0;
            n_q            <= '0;
            m_q            <= '0;
            row_q          <= '0;
            col_q          <= '0;
            acc_q          <= 1'b0;
            base_q         <= '0;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            rd_en_o        <= 1'b0;
            rd_addr_o      <= '0;
            flags_o        <= '0;
            finish_write_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (finish_mul_i) begin
                        c_q     <= c_matrix_i;
                        n_q     <= n_dim_i;
                        m_q     <= m_dim_i;
                        acc_q   <= acc_mode_i;
                        base_q  <= sp_base_i;
                        flags_o <= flags_i;
                        row_q   <= '0;
                        col_q   <= '0;
                        // Element (0,0) sits at the base address and flat index 0.
                        if (acc_mode_i) begin
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= sp_base_i;
                            state_q   <= RD_REQ;
                        end else begin
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= sp_base_i;
                            wr_data_o <= c_matrix_i[BUS_WIDTH-1:0];
                            state_q   <= WRITE;
                        end
                    end
                end
                RD_REQ: begin
                    rd_en_o <= 1'b0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_valid_i) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= rd_addr_o;
                        wr_data_o <= sum;
                        flags_o   <= flags_d;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ready_i) begin
                        if (last_elem) begin
                            wr_en_o        <= 1'b0;
                            finish_write_o <= 1'b1;
                            state_q        <= DONE;
                        end else begin
                            row_q <= row_d;
                            col_q <= col_d;
                            if (acc_q) begin
                                wr_en_o   <= 1'b0;
                                rd_en_o   <= 1'b1;
                                rd_addr_o <= addr_next;
                                state_q   <= RD_REQ;
                            end else begin
                                wr_addr_o <= addr_next;
                                wr_data_o <= c_next;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!finish_mul_i) begin
                        finish_write_o <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_writer.sv
// Self-checking bench for matmul_result_writer: scratchpad/read-responder model
// plus an element-level reference of the drain (order, addresses, saturation).
module tb_matmul_result_writer;

    localparam int BW  = 16;
    localparam int AW  = 5;
    localparam int MD  = 2;
    localparam int NEL = MD * MD;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              finish_mul_i;
    logic [NEL*BW-1:0] c_matrix_i;
    logic [NEL-1:0]    flags_i;
    logic [1:0]        n_dim_i;
    logic [1:0]        m_dim_i;
    logic              acc_mode_i;
    logic [AW-1:0]     sp_base_i;
    logic              wr_en_o;
    logic [AW-1:0]     wr_addr_o;
    logic [BW-1:0]     wr_data_o;
    logic              wr_ready_i;
    logic              rd_en_o;
    logic [AW-1:0]     rd_addr_o;
    logic [BW-1:0]     rd_data_i = '0;
    logic              rd_valid_i = 1'b0;
    logic [NEL-1:0]    flags_o;
    logic              finish_write_o;

    logic              fixed_rdy = 1'b1;
    logic              rand_ready = 1'b0;
    logic              rnd_rdy = 1'b1;
    int                rd_lat = 2;
    int                cyc = 0;
    int                errors = 0;
    int                checks = 0;

    logic [BW-1:0]     mem [32];
    logic [BW-1:0]     job_c [MD][MD];
    wr_t               log_q[$];
    exp_t              exp_q[$];
    logic [NEL-1:0]    exp_flags;
    logic [AW-1:0]     rd_a;

    matmul_result_writer #(
        .DATA_WIDTH (8),
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .finish_mul_i   (finish_mul_i),
        .c_matrix_i     (c_matrix_i),
        .flags_i        (flags_i),
        .n_dim_i        (n_dim_i),
        .m_dim_i        (m_dim_i),
        .acc_mode_i     (acc_mode_i),
        .sp_base_i      (sp_base_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_ready_i     (wr_ready_i),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_i      (rd_data_i),
        .rd_valid_i     (rd_valid_i),
        .flags_o        (flags_o),
        .finish_write_o (finish_write_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    assign wr_ready_i = rand_ready ? rnd_rdy : fixed_rdy;

    always @(posedge clk_i) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    // Accepted writes, sampled mid-cycle while ready is stable.
    always @(negedge clk_i) begin
        if (wr_en_o && wr_ready_i) log_q.push_back('{wr_addr_o, wr_data_o, cyc});
    end

    // Scratchpad read port: data arrives rd_lat cycles after the request is seen.
    always @(negedge clk_i) begin
        if (rd_en_o) begin
            rd_a = rd_addr_o;
            repeat (rd_lat) @(posedge clk_i);
            #1;
            rd_data_i  = mem[rd_a];
            rd_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            rd_valid_i = 1'b0;
            rd_data_i  = BW'($urandom);
        end
    end

    function automatic logic [BW-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 16'h7F00 | 16'($urandom_range(0, 255));
            1:       return 16'h8000 | 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    // Reference: row-major walk, row-major addresses, plain integer saturation.
    task automatic build_expected(input int n, input int m, input bit acc,
                                  input logic [AW-1:0] base, input logic [NEL-1:0] flg);
        logic [AW-1:0] a;
        int            s;
        exp_q.delete();
        exp_flags = flg;
        for (int r = 0; r <= n; r++) begin
            for (int c = 0; c <= m; c++) begin
                a = AW'(int'(base) + r * MD + c);
                if (acc) begin
                    s = int'($signed(mem[a])) + int'($signed(job_c[r][c]));
                    if (s > 32767) begin
                        s = 32767;
                        exp_flags[c*MD+r] = 1'b1;
                    end else if (s < -32768) begin
                        s = -32768;
                        exp_flags[c*MD+r] = 1'b1;
                    end
                    exp_q.push_back('{a, BW'(s)});
                end else begin
                    exp_q.push_back('{a, job_c[r][c]});
                end
            end
        end
    endtask

    task automatic drive_job(input int n, input int m, input bit acc, input logic [AW-1:0] base,
                             input logic [NEL-1:0] flg, input bit scramble,
                             output int s_cyc, output int f_cyc, output bit to);
        @(posedge clk_i);
        #1;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                c_matrix_i[(c*MD+r)*BW +: BW] = job_c[r][c];
        flags_i      = flg;
        n_dim_i      = 2'(n);
        m_dim_i      = 2'(m);
        acc_mode_i   = acc;
        sp_base_i    = base;
        finish_mul_i = 1'b1;
        s_cyc        = cyc;
        f_cyc        = -1;
        to           = 1'b1;
        if (scramble) begin
            @(posedge clk_i);
            #1;
            c_matrix_i = {$urandom, $urandom};
            flags_i    = NEL'($urandom);
            n_dim_i    = 2'($urandom);
            m_dim_i    = 2'($urandom);
            acc_mode_i = 1'($urandom);
            sp_base_i  = AW'($urandom);
        end
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_i);
            if (finish_write_o) begin
                to    = 1'b0;
                f_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic release_job(output bit held, output bit dropped);
        @(posedge clk_i);
        #1;
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        held = finish_write_o;
        @(negedge clk_i);
        dropped = !finish_write_o;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o, flags_o, finish_write_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr_en=%b wr_addr=%0d wr_data=%h rd_en=%b rd_addr=%0d flags=%b fin=%b, want all 0",
                     wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o, flags_o, finish_write_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({wr_en_o, rd_en_o, finish_write_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_quiet: got wr_en=%b rd_en=%b fin=%b, want 0 0 0", wr_en_o, rd_en_o, finish_write_o);
        end
    endtask

    task automatic test_overwrite;
        int s, f, start;
        bit to, held, dropped;
        job_c[0][0] = 16'd1; job_c[0][1] = 16'd2; job_c[1][0] = 16'd3; job_c[1][1] = 16'd4;
        rand_ready = 1'b0; fixed_rdy = 1'b1;
        start = log_q.size();
        build_expected(1, 1, 1'b0, 5'd4, 4'b0000);
        drive_job(1, 1, 1'b0, 5'd4, 4'b0000, 1'b1, s, f, to);
        checks++;
        if (to) begin errors++; $display("FAIL ow_timeout: got no finish_write_o, want finish"); end
        checks++;
        if (log_q.size() - start != 4) begin
            errors++; $display("FAIL ow_count: got %0d writes, want 4", log_q.size() - start);
        end
        for (int i = 0; i < exp_q.size() && start + i < log_q.size(); i++) begin
            checks++;
            if (log_q[start+i].addr !== exp_q[i].addr || log_q[start+i].data !== exp_q[i].data ||
                log_q[start+i].cyc != s + 1 + i) begin
                errors++;
                $display("FAIL ow_write%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", i,
                         log_q[start+i].addr, log_q[start+i].data, log_q[start+i].cyc,
                         exp_q[i].addr, exp_q[i].data, s + 1 + i);
            end
        end
        checks++;
        if (f != s + 5) begin errors++; $display("FAIL ow_finish_cycle: got %0d, want %0d", f, s + 5); end
        release_job(held, dropped);
        checks++;
        if (!held || !dropped) begin
            errors++; $display("FAIL ow_finish_drop: got held=%b dropped=%b, want 1 1", held, dropped);
        end
    endtask

    task automatic test_partial;
        int s, f, start;
        bit to, held, dropped;
        job_c[0][0] = 16'd9; job_c[0][1] = 16'hFFF9; job_c[1][0] = rand_word(); job_c[1][1] = rand_word();
        start = log_q.size();
        build_expected(0, 1, 1'b0, 5'd0, 4'b0000);
        drive_job(0, 1, 1'b0, 5'd0, 4'b0000, 1'b0, s, f, to);
        checks++;
        if (to || log_q.size() - start != 2) begin
            errors++; $display("FAIL partial_count: got %0d writes (timeout=%b), want 2", log_q.size() - start, to);
        end
        for (int i = 0; i < exp_q.size() && start + i < log_q.size(); i++) begin
            checks++;
            if (log_q[start+i].addr !== exp_q[i].addr || log_q[start+i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL partial_write%0d: got addr=%0d data=%h, want addr=%0d data=%h", i,
                         log_q[start+i].addr, log_q[start+i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        release_job(held, dropped);
    endtask

    task automatic test_backpressure;
        int s, f, start;
        bit to, held, dropped;
        logic [AW-1:0] base;
        for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) job_c[r][c] = rand_word();
        base  = AW'($urandom);
        start = log_q.size();
        build_expected(1, 1, 1'b0, base, 4'b0000);
        fork
            drive_job(1, 1, 1'b0, base, 4'b0000, 1'b1, s, f, to);
            begin
                repeat (3) @(posedge clk_i);
                #1;
                fixed_rdy = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_i);
                    checks++;
                    if (wr_en_o !== 1'b1 || wr_addr_o !== exp_q[1].addr || wr_data_o !== exp_q[1].data) begin
                        errors++;
                        $display("FAIL bp_hold%0d: got en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h", k,
                                 wr_en_o, wr_addr_o, wr_data_o, exp_q[1].addr, exp_q[1].data);
                    end
                    @(posedge clk_i);
                end
                #1;
                fixed_rdy = 1'b1;
            end
        join
        checks++;
        if (to || log_q.size() - start != 4) begin
            errors++; $display("FAIL bp_count: got %0d writes (timeout=%b), want 4", log_q.size() - start, to);
        end
        for (int i = 0; i < exp_q.size() && start + i < log_q.size(); i++) begin
            checks++;
            if (log_q[start+i].addr !== exp_q[i].addr || log_q[start+i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL bp_write%0d: got addr=%0d data=%h, want addr=%0d data=%h", i,
                         log_q[start+i].addr, log_q[start+i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (f != s + 8) begin errors++; $display("FAIL bp_finish_cycle: got %0d, want %0d", f, s + 8); end
        release_job(held, dropped);
    endtask

    task automatic test_accumulate;
        int s, f, start;
        bit to, held, dropped;
        mem[8] = 16'h7FF0; mem[9] = 16'hFFFB;
        job_c[0][0] = 16'h0020; job_c[0][1] = 16'd3; job_c[1][0] = rand_word(); job_c[1][1] = rand_word();
        rd_lat = 2;
        start  = log_q.size();
        build_expected(0, 1, 1'b1, 5'd8, 4'b0000);
        drive_job(0, 1, 1'b1, 5'd8, 4'b0000, 1'b1, s, f, to);
        checks++;
        if (to || log_q.size() - start != 2) begin
            errors++; $display("FAIL acc_count: got %0d writes (timeout=%b), want 2", log_q.size() - start, to);
        end
        for (int i = 0; i < exp_q.size() && start + i < log_q.size(); i++) begin
            checks++;
            if (log_q[start+i].addr !== exp_q[i].addr || log_q[start+i].data !== exp_q[i].data) begin
                errors++;
                $display("FAIL acc_write%0d: got addr=%0d data=%h, want addr=%0d data=%h", i,
                         log_q[start+i].addr, log_q[start+i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        if (log_q.size() - start >= 2) begin
            checks++;
            if (log_q[start].cyc != s + 4 || log_q[start+1].cyc - log_q[start].cyc < 3) begin
                errors++;
                $display("FAIL acc_timing: got first=%0d gap=%0d, want first=%0d gap>=3",
                         log_q[start].cyc, log_q[start+1].cyc - log_q[start].cyc, s + 4);
            end
        end
        checks++;
        if (flags_o !== exp_flags) begin
            errors++; $display("FAIL acc_flags: got %b, want %b", flags_o, exp_flags);
        end
        for (int i = start; i < log_q.size(); i++) mem[log_q[i].addr] = log_q[i].data;
        release_job(held, dropped);
    endtask

    task automatic test_flags;
        int s, f;
        bit to, held, dropped;
        for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) job_c[r][c] = rand_word();
        drive_job(1, 1, 1'b0, 5'd12, 4'b0010, 1'b1, s, f, to);
        checks++;
        if (to || flags_o !== 4'b0010) begin
            errors++; $display("FAIL flags_done: got %b (timeout=%b), want 0010", flags_o, to);
        end
        release_job(held, dropped);
        checks++;
        if (flags_o !== 4'b0010) begin errors++; $display("FAIL flags_idle_hold: got %b, want 0010", flags_o); end
        drive_job(1, 0, 1'b0, 5'd12, 4'b0000, 1'b0, s, f, to);
        checks++;
        if (to || flags_o !== 4'b0000) begin
            errors++; $display("FAIL flags_clear: got %b (timeout=%b), want 0000", flags_o, to);
        end
        release_job(held, dropped);
    endtask

    task automatic test_random;
        int s, f, start, n, m;
        bit to, held, dropped, acc;
        logic [AW-1:0]  base;
        logic [NEL-1:0] flg;
        for (int i = 0; i < 32; i++) mem[i] = rand_word();
        rand_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) job_c[r][c] = rand_word();
            n      = $urandom_range(0, 1);
            m      = $urandom_range(0, 1);
            acc    = 1'($urandom);
            base   = AW'($urandom);
            flg    = NEL'($urandom);
            rd_lat = $urandom_range(1, 3);
            start  = log_q.size();
            build_expected(n, m, acc, base, flg);
            drive_job(n, m, acc, base, flg, 1'b1, s, f, to);
            checks++;
            if (to || log_q.size() - start != exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_count: got %0d writes (timeout=%b), want %0d", t, log_q.size() - start, to, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && start + i < log_q.size(); i++) begin
                checks++;
                if (log_q[start+i].addr !== exp_q[i].addr || log_q[start+i].data !== exp_q[i].data) begin
                    errors++;
                    $display("FAIL rnd%0d_write%0d: got addr=%0d data=%h, want addr=%0d data=%h", t, i,
                             log_q[start+i].addr, log_q[start+i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
            checks++;
            if (flags_o !== exp_flags) begin
                errors++; $display("FAIL rnd%0d_flags: got %b, want %b", t, flags_o, exp_flags);
            end
            for (int i = start; i < log_q.size(); i++) mem[log_q[i].addr] = log_q[i].data;
            release_job(held, dropped);
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain;
        int s, restart, start;
        bit to;
        for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) job_c[r][c] = rand_word();
        build_expected(1, 1, 1'b0, 5'd20, 4'b1011);
        @(posedge clk_i);
        #1;
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
                c_matrix_i[(c*MD+r)*BW +: BW] = job_c[r][c];
        flags_i = 4'b1011; n_dim_i = 2'd1; m_dim_i = 2'd1; acc_mode_i = 1'b0; sp_base_i = 5'd20;
        finish_mul_i = 1'b1;
        start = log_q.size();
        to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (log_q.size() - start >= 2) begin to = 1'b0; break; end
        end
        checks++;
        if (to) begin errors++; $display("FAIL rst_pre_writes: got %0d writes, want 2", log_q.size() - start); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o, flags_o, finish_write_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got wr_en=%b wr_addr=%0d wr_data=%h rd_en=%b rd_addr=%0d flags=%b fin=%b, want all 0",
                     wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o, flags_o, finish_write_o);
        end
        restart = log_q.size();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        s  = cyc;
        to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (finish_write_o) begin to = 1'b0; break; end
        end
        checks++;
        if (to || log_q.size() - restart != 4) begin
            errors++; $display("FAIL rst_restart_count: got %0d writes (timeout=%b), want 4", log_q.size() - restart, to);
        end
        for (int i = 0; i < exp_q.size() && restart + i < log_q.size(); i++) begin
            checks++;
            if (log_q[restart+i].addr !== exp_q[i].addr || log_q[restart+i].data !== exp_q[i].data ||
                log_q[restart+i].cyc != s + 1 + i) begin
                errors++;
                $display("FAIL rst_restart_write%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", i,
                         log_q[restart+i].addr, log_q[restart+i].data, log_q[restart+i].cyc,
                         exp_q[i].addr, exp_q[i].data, s + 1 + i);
            end
        end
        checks++;
        if (flags_o !== 4'b1011) begin errors++; $display("FAIL rst_restart_flags: got %b, want 1011", flags_o); end
        @(posedge clk_i);
        #1;
        finish_mul_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        finish_mul_i = 1'b0;
        c_matrix_i   = '0;
        flags_i      = '0;
        n_dim_i      = '0;
        m_dim_i      = '0;
        acc_mode_i   = 1'b0;
        sp_base_i    = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) job_c[r][c] = '0;
        test_reset();
        test_overwrite();
        test_partial();
        test_backpressure();
        test_accumulate();
        test_flags();
        test_random();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
